vga_timing_controller: RTL

VGA_TIMING_CONTROLLER -- requirements
Module: vga_timing_controller

---
 rtl/vga_timing_controller.sv | 137 +++++++++++++
 1 files changed

// File: rtl/vga_timing_controller.sv
// VGA timing generator running at 4 clks per pixel slot: requests each pixel from an
// external generator and displays it two slots later, with sync and blanking aligned.
module vga_timing_controller #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] vga_data,
   output logic       req,
   output logic [8:0] row,
   output logic [9:0] column,
   output logic [7:0] rgb,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_start
);
   localparam logic [9:0] H_VIS_L  = 10'(H_VISIBLE);
   localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] V_VIS_L  = 10'(V_VISIBLE);
   localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [1:0] phase_q, phase_d;
   logic [9:0] h_q, h_d;
   logic [9:0] v_q, v_d;
   logic [1:0] vis_dly_q, vis_dly_d;
   logic [1:0] hs_dly_q, hs_dly_d;
   logic [1:0] vs_dly_q, vs_dly_d;
   logic [1:0] fs_dly_q, fs_dly_d;
   logic       req_q, req_d;
   logic [8:0] row_q, row_d;
   logic [9:0] column_q, column_d;
   logic [7:0] rgb_q, rgb_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       frame_start_q, frame_start_d;

   logic slot;
   logic vis_raw, hs_raw, vs_raw, fs_raw;

   always_comb begin
      slot    = (phase_q == 2'd3);
      vis_raw = (h_q < H_VIS_L) && (v_q < V_VIS_L);
      hs_raw  = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
      vs_raw  = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
      fs_raw  = (h_q == 10'd0) && (v_q == 10'd0);

      phase_d       = phase_q + 2'd1;
      h_d           = h_q;
      v_d           = v_q;
      vis_dly_d     = vis_dly_q;
      hs_dly_d      = hs_dly_q;
      vs_dly_d      = vs_dly_q;
      fs_dly_d      = fs_dly_q;
      req_d         = 1'b0;
      row_d         = row_q;
      column_d      = column_q;
      rgb_d         = rgb_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      frame_start_d = 1'b0;

      // Everything except the phase counter and the req/frame_start pulses moves on slot edges.
      if (slot) begin
         req_d         = vis_raw;
         row_d         = v_q[8:0];
         column_d      = h_q;
         vis_dly_d     = {vis_dly_q[0], vis_raw};
         hs_dly_d      = {hs_dly_q[0], hs_raw};
         vs_dly_d      = {vs_dly_q[0], vs_raw};
         fs_dly_d      = {fs_dly_q[0], fs_raw};
         rgb_d         = vis_dly_q[1] ? vga_data : 8'h00;
         hsync_d       = ~hs_dly_q[1];
         vsync_d       = ~vs_dly_q[1];
         frame_start_d = fs_dly_q[1];
         if (h_q == H_LAST) begin
            h_d = 10'd0;
            v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
         end else begin
            h_d = h_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q       <= 2'd0;
         h_q           <= 10'd0;
         v_q           <= 10'd0;
         vis_dly_q     <= 2'b00;
         hs_dly_q      <= 2'b00;
         vs_dly_q      <= 2'b00;
         fs_dly_q      <= 2'b00;
         req_q         <= 1'b0;
         row_q         <= 9'd0;
         column_q      <= 10'd0;
         rgb_q         <= 8'h00;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         phase_q       <= phase_d;
         h_q           <= h_d;
         v_q           <= v_d;
         vis_dly_q     <= vis_dly_d;
         hs_dly_q      <= hs_dly_d;
         vs_dly_q      <= vs_dly_d;
         fs_dly_q      <= fs_dly_d;
         req_q         <= req_d;
         row_q         <= row_d;
         column_q      <= column_d;
         rgb_q         <= rgb_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign req         = req_q;
   assign row         = row_q;
   assign column      = column_q;
   assign rgb         = rgb_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign frame_start = frame_start_q;

endmodule
